// File: rtl/adder_rr_arbiter.sv
// Ripple-carry adder: N-bit combinational add with carry-in and carry-out.
// Latency: purely combinational; the caller decides how long to let it settle.
// Backpressure: none, it has no handshake.
module ripple_carry #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] o_o,
  output logic         c_o
);

  logic [N:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign o_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o = carry[N];

endmodule

// Round-robin arbiter sharing one ripple_carry between two requesters.
// Latency: SETTLE+1 cycles from request acceptance to response valid.
// Backpressure: requests stall while busy; a response holds until its requester takes it.
module adder_rr_arbiter #(
  parameter int N      = 8,
  parameter int SETTLE = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [1:0]   req_valid_i,
  output logic [1:0]   req_ready_o,
  input  logic [N-1:0] a0_i,
  input  logic [N-1:0] b0_i,
  input  logic         c0_i,
  input  logic [N-1:0] a1_i,
  input  logic [N-1:0] b1_i,
  input  logic         c1_i,
  output logic [1:0]   rsp_valid_o,
  input  logic [1:0]   rsp_ready_i,
  output logic [N-1:0] rsp_sum_o,
  output logic         rsp_c_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t       state;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         op_c;
  logic [3:0]   cnt;
  logic         grant;
  logic         last;
  logic         win_vld;
  logic         win_idx;
  logic [N-1:0] add_sum;
  logic         add_c;

  ripple_carry #(.N(N)) u_add (
    .a_i (op_a),
    .b_i (op_b),
    .c_i (op_c),
    .o_o (add_sum),
    .c_o (add_c)
  );

  // On a tie the requester that was not served last wins.
  always_comb begin
    win_vld     = |req_valid_i;
    win_idx     = (req_valid_i == 2'b11) ? ~last : req_valid_i[1];
    req_ready_o = 2'b00;
    if (state == ST_IDLE && rst_ni && win_vld)
      req_ready_o[win_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      op_a        <= '0;
      op_b        <= '0;
      op_c        <= 1'b0;
      cnt         <= 4'd0;
      grant       <= 1'b0;
      last        <= 1'b1;
      rsp_valid_o <= 2'b00;
      rsp_sum_o   <= '0;
      rsp_c_o     <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            op_a   <= win_idx ? a1_i : a0_i;
            op_b   <= win_idx ? b1_i : b0_i;
            op_c   <= win_idx ? c1_i : c0_i;
            grant  <= win_idx;
            last   <= win_idx;
            cnt    <= CNT_LOAD;
            busy_o <= 1'b1;
            state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == 4'd0) begin
            rsp_sum_o   <= add_sum;
            rsp_c_o     <= add_c;
            rsp_valid_o <= grant ? 2'b10 : 2'b01;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i[grant]) begin
            rsp_valid_o <= 2'b00;
            busy_o      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter: three instances (SETTLE 2, 1, 4) with
// per-instance expected-response queues drained by independent monitors.
module tb_adder_rr_arbiter;

  localparam int NDUT = 3;
  localparam int SETTLE_OF [NDUT] = '{2, 1, 4};

  typedef struct packed {
    logic [1:0] vld;
    logic [7:0] sum;
    logic       c;
  } rsp_t;

  typedef struct packed {
    logic       r;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid [NDUT];
  logic [1:0] req_ready [NDUT];
  logic [7:0] a0 [NDUT];
  logic [7:0] b0 [NDUT];
  logic       c0 [NDUT];
  logic [7:0] a1 [NDUT];
  logic [7:0] b1 [NDUT];
  logic       c1 [NDUT];
  logic [1:0] rsp_valid [NDUT];
  logic [1:0] rsp_ready [NDUT];
  logic [7:0] rsp_sum [NDUT];
  logic       rsp_c [NDUT];
  logic       busy [NDUT];

  rsp_t exp_q [NDUT][$];
  int   cyc;
  int   n_pass;
  int   n_total;

  vec_t vecs [6] = '{
    '{1'b0, 8'h06, 8'h06, 1'b0, 8'h0C, 1'b0},
    '{1'b0, 8'h06, 8'h06, 1'b1, 8'h0D, 1'b0},
    '{1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1},
    '{1'b1, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1},
    '{1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1},
    '{1'b1, 8'h00, 8'hFF, 1'b0, 8'hFF, 1'b0}
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    else
      n_pass++;
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    rsp_t got;
    rsp_t e;
    rsp_t held;
    bit   in_rsp;
    int   acc_cyc;

    adder_rr_arbiter #(.N(8), .SETTLE(SETTLE_OF[g])) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .a0_i        (a0[g]),
      .b0_i        (b0[g]),
      .c0_i        (c0[g]),
      .a1_i        (a1[g]),
      .b1_i        (b1[g]),
      .c1_i        (c1[g]),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_ready_i (rsp_ready[g]),
      .rsp_sum_o   (rsp_sum[g]),
      .rsp_c_o     (rsp_c[g]),
      .busy_o      (busy[g])
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        in_rsp = 1'b0;
      end else begin
        if (busy[g])
          check("ready_while_busy", 32'(req_ready[g]), 32'd0);
        if ((req_valid[g] & req_ready[g]) != 2'b00)
          acc_cyc = cyc;
        got = {rsp_valid[g], rsp_sum[g], rsp_c[g]};
        if (rsp_valid[g] != 2'b00) begin
          if (!in_rsp) begin
            if (exp_q[g].size() == 0) begin
              check("unexpected_rsp", 32'(got), 32'd0);
            end else begin
              e = exp_q[g].pop_front();
              check("rsp_valid", 32'(got.vld), 32'(e.vld));
              check("rsp_sum", 32'(got.sum), 32'(e.sum));
              check("rsp_c", 32'(got.c), 32'(e.c));
              check("latency", 32'(cyc - acc_cyc), 32'(SETTLE_OF[g] + 1));
            end
            held   = got;
            in_rsp = 1'b1;
          end else begin
            check("rsp_stable", 32'(got), 32'(held));
          end
          if ((rsp_valid[g] & rsp_ready[g]) != 2'b00)
            in_rsp = 1'b0;
        end else begin
          in_rsp = 1'b0;
        end
      end
    end
  end

  task automatic push_exp(input int g, input logic r, input logic [7:0] s, input logic co);
    rsp_t e;
    e.vld = r ? 2'b10 : 2'b01;
    e.sum = s;
    e.c   = co;
    exp_q[g].push_back(e);
  endtask

  // Returns just after the acceptance edge with the granted one-hot in gnt.
  task automatic wait_grant(input int g, output logic [1:0] gnt);
    gnt = 2'b00;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if ((req_valid[g] & req_ready[g]) != 2'b00) begin
        gnt = req_ready[g];
        break;
      end
    end
    if (gnt == 2'b00)
      check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int g, input logic r, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] s, input logic co);
    logic [1:0] gnt;
    @(posedge clk);
    #1;
    if (r) begin
      a1[g] = a; b1[g] = b; c1[g] = c;
    end else begin
      a0[g] = a; b0[g] = b; c0[g] = c;
    end
    req_valid[g][r] = 1'b1;
    push_exp(g, r, s, co);
    wait_grant(g, gnt);
    req_valid[g][r] = 1'b0;
    check("grant", 32'(gnt), r ? 32'd2 : 32'd1);
  endtask

  task automatic wait_idle(input int g);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (exp_q[g].size() == 0 && !busy[g] && rsp_valid[g] == 2'b00)
        break;
    end
    check("drain", 32'(exp_q[g].size()) | 32'(busy[g]), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready[0]), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid[0]), 32'd0);
    check({tag, "_rsp_sum"}, 32'(rsp_sum[0]), 32'd0);
    check({tag, "_rsp_c"}, 32'(rsp_c[0]), 32'd0);
    check({tag, "_busy"}, 32'(busy[0]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] gnt;
    logic       seen;
    n_pass  = 0;
    n_total = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      req_valid[g] = 2'b11;
      rsp_ready[g] = 2'b11;
      a0[g] = 8'h0; b0[g] = 8'h0; c0[g] = 1'b0;
      a1[g] = 8'h0; b1[g] = 8'h0; c1[g] = 1'b0;
    end

    // Reset state, with both requests valid so ready must be held low.
    repeat (3) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check("rst_req_ready", 32'(req_ready[g]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[g]), 32'd0);
      check("rst_rsp_sum", 32'(rsp_sum[g]), 32'd0);
      check("rst_rsp_c", 32'(rsp_c[g]), 32'd0);
      check("rst_busy", 32'(busy[g]), 32'd0);
      req_valid[g] = 2'b00;
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors on every SETTLE variant.
    for (int g = 0; g < NDUT; g++) begin
      for (int v = 0; v < 6; v++)
        issue(g, vecs[v].r, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].s, vecs[v].co);
      wait_idle(g);
    end

    // Both requesters valid: grants alternate starting at 0 after reset.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a0[0] = 8'h11; b0[0] = 8'h22; c0[0] = 1'b0;
    a1[0] = 8'hF0; b1[0] = 8'h20; c1[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(0, 1'b0, 8'h33, 1'b0);
      else            push_exp(0, 1'b1, 8'h11, 1'b1);
    end
    req_valid[0] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_grant(0, gnt);
      check("alt_grant", 32'(gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    req_valid[0] = 2'b00;
    wait_idle(0);

    // Backpressure: response held, competing request stalls, stray ready ignored.
    @(posedge clk);
    #1;
    rsp_ready[0] = 2'b00;
    issue(0, 1'b0, 8'h0A, 8'h05, 1'b0, 8'h0F, 1'b0);
    a1[0] = 8'h33; b1[0] = 8'h44; c1[0] = 1'b1;
    push_exp(0, 1'b1, 8'h78, 1'b0);
    req_valid[0] = 2'b10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_no_accept", 32'(req_ready[0]), 32'd0);
      if (k == 4) rsp_ready[0] = 2'b10;
    end
    check("bp_valid_held", 32'(rsp_valid[0]), 32'd1);
    check("bp_sum_held", 32'(rsp_sum[0]), 32'h0F);
    rsp_ready[0] = 2'b11;
    wait_grant(0, gnt);
    req_valid[0] = 2'b00;
    check("bp_next_grant", 32'(gnt), 32'd2);
    wait_idle(0);

    // Reset during SETTLE discards the operation; next tie goes to requester 0.
    issue(0, 1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q[0].delete();
    #1;
    check_reset_outputs("rst_settle");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a0[0] = 8'h10; b0[0] = 8'h20; c0[0] = 1'b0;
    a1[0] = 8'h01; b1[0] = 8'h01; c1[0] = 1'b0;
    push_exp(0, 1'b0, 8'h30, 1'b0);
    req_valid[0] = 2'b11;
    wait_grant(0, gnt);
    req_valid[0] = 2'b00;
    check("tie_after_rst_settle", 32'(gnt), 32'd1);
    wait_idle(0);

    // Reset during RESP drops the pending response.
    rsp_ready[0] = 2'b00;
    issue(0, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rsp_valid[0] != 2'b00) begin
        seen = 1'b1;
        break;
      end
    end
    check("resp_reached", 32'(seen), 32'd1);
    #1;
    rst_n = 1'b0;
    exp_q[0].delete();
    #1;
    check_reset_outputs("rst_resp");
    rsp_ready[0] = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    a0[0] = 8'hFF; b0[0] = 8'h01; c0[0] = 1'b1;
    push_exp(0, 1'b0, 8'h01, 1'b1);
    req_valid[0] = 2'b11;
    wait_grant(0, gnt);
    req_valid[0] = 2'b00;
    check("tie_after_rst_resp", 32'(gnt), 32'd1);
    wait_idle(0);
    repeat (5) @(negedge clk);

    for (int g = 0; g < NDUT; g++)
      check("queue_empty", 32'(exp_q[g].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
